// File: rtl/risc_v_32_store_unit.sv
// risc_v_32_store_unit
// MEM-stage store path. It lane-aligns sb/sh/sw data, builds byte enables,
// and rejects misaligned stores with a one-cycle misalign pulse. Accepted
// stores go into a DEPTH-entry FIFO, which drains to the data-memory write
// port over a req/ack handshake.
// Ports:
//   clk, clrn                 clock / async active-low reset
//   s_valid, s_ready          EX store handshake
//   m_addr, d_t_mem           store byte address and rs2 data
//   inst_decode               one-hot decode, [15]=sb [16]=sh [17]=sw
//   mem_req/addr/wdata/be     write port, head of buffer
//   mem_ack                   memory accepts head
//   misalign, misalign_addr   misaligned-store pulse and sticky address
//   ld_check, ld_addr         load word-overlap query
//   ld_hazard                 pending store hits load word
//   sb_empty, sb_count        buffer occupancy
module risc_v_32_store_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      m_addr,
  input  logic [31:0]      d_t_mem,
  input  logic [36:0]      inst_decode,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  output logic             misalign,
  output logic [31:0]      misalign_addr,
  input  logic             ld_check,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic        accept, push, pop, is_sb, is_sh, is_sw, bad;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [1:0]  a;

  // Ready depends only on registered count, so a pop never frees a slot in
  // the same cycle.
  assign s_ready  = (count < FULL);
  assign accept   = s_valid & s_ready;
  assign mem_req  = (count != '0);
  assign pop      = mem_req & mem_ack;
  assign sb_empty = (count == '0);
  assign sb_count = count;
  assign a        = m_addr[1:0];

  // sw > sh > sb.
  assign is_sw = inst_decode[17];
  assign is_sh = ~inst_decode[17] & inst_decode[16];
  assign is_sb = ~inst_decode[17] & ~inst_decode[16] & inst_decode[15];

  always_comb begin
    al_wdata = '0;
    al_be    = '0;
    bad      = 1'b0;
    if (is_sw) begin
      al_wdata = d_t_mem;
      al_be    = 4'b1111;
      bad      = (a != 2'b00);
    end else if (is_sh) begin
      al_wdata = {2{d_t_mem[15:0]}};
      al_be    = a[1] ? 4'b1100 : 4'b0011;
      bad      = a[0];
    end else if (is_sb) begin
      al_wdata = {4{d_t_mem[7:0]}};
      al_be    = 4'b0001 << a;
    end
  end

  // A decode with no store bit is consumed without effect.
  assign push = accept & (is_sw | is_sh | is_sb) & ~bad;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      misalign <= accept & bad;
      if (accept & bad) misalign_addr <= m_addr;
      if (push) begin
        addr_q[wr_ptr]  <= {m_addr[31:2], 2'b00};
        wdata_q[wr_ptr] <= al_wdata;
        be_q[wr_ptr]    <= al_be;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign mem_addr  = addr_q[rd_ptr];
  assign mem_wdata = wdata_q[rd_ptr];
  assign mem_be    = be_q[rd_ptr];

  // An entry is live if its distance from the head is below count. The head
  // being acked this cycle is still live, which keeps the check conservative.
  logic             hit;
  logic [PTR_W-1:0] off;
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (((PTR_W+1)'(off) < count) && (addr_q[i][31:2] == ld_addr[31:2]))
        hit = 1'b1;
    end
  end
  assign ld_hazard = ld_check & hit;

endmodule
